// File: rtl/button_conditioner.sv
// Conditions one raw active-low pushbutton into debounced, clock-synchronous
// level and single-cycle press / release / hold pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int HOLD_CYCLES     = 6000000,
  parameter int CNT_WIDTH       = $clog2(((DEBOUNCE_CYCLES > HOLD_CYCLES) ?
                                          DEBOUNCE_CYCLES : HOLD_CYCLES) + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse
);

  localparam logic [CNT_WIDTH-1:0] DEB_MAX   = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX  = CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic [CNT_WIDTH-1:0] lim);
    return (v >= lim) ? lim : v + CNT_ONE;
  endfunction

  logic                 sync_p0, sync_p1;
  logic                 btn_s;
  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] hold_cnt, hold_nxt;
  logic                 pressed_nxt, press_nxt, release_nxt, hold_p_nxt;

  // Stage p0/p1: two-flop synchroniser, resets to the released level
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= ~button_in;
      sync_p1 <= sync_p0;
    end
  end

  assign btn_s = sync_p1;

  // Debounce / hold FSM: next state and registered-output precursors
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hold_nxt    = hold_cnt;
    pressed_nxt = pressed;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    hold_p_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_MAX) begin
          state_nxt   = PRESSED;
          pressed_nxt = 1'b1;
          press_nxt   = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end else begin
          // Saturation at HOLD_MAX guarantees a single hold pulse per press
          hold_nxt   = sat_inc(hold_cnt, HOLD_MAX);
          hold_p_nxt = (hold_cnt == HOLD_LAST);
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_MAX) begin
          state_nxt   = IDLE;
          pressed_nxt = 1'b0;
          release_nxt = 1'b1;
          hold_nxt    = '0;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage p2: state, counters and all outputs registered together
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      hold_cnt      <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      hold_cnt      <= hold_nxt;
      pressed       <= pressed_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      hold_pulse    <= hold_p_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized bouncing,
// compared every cycle against a run-length reference model.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic button_in = 1'b1;
  logic pressed, press_pulse, release_pulse, hold_pulse;
  logic [3:0] dut_o;

  int total = 0;
  int bad   = 0;

  // Reference model: synchroniser delay line, accepted level, run length of
  // samples disagreeing with it, and time held; exp_o = {lvl,press,rel,hold}
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_acc = 1'b0;
  int   m_run = 0, m_hold = 0;
  logic [3:0] exp_o = 4'b0000;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button_in    (button_in),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .hold_pulse   (hold_pulse)
  );

  assign dut_o = {pressed, press_pulse, release_pulse, hold_pulse};

  always #5 clock = ~clock;

  task automatic cycle();
    logic b;
    @(posedge clock);
    exp_o[2:0] = 3'b000;
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_acc = 1'b0;
      m_run = 0; m_hold = 0; exp_o = 4'b0000;
    end else begin
      b = m_s2;
      if (b != m_acc) begin
        m_run++;
        if (m_run == D + 1) begin
          m_acc = b;
          m_run = 0;
          if (b) exp_o[2] = 1'b1;
          else begin
            exp_o[1] = 1'b1;
            m_hold   = 0;
          end
        end
      end else begin
        if (m_acc && m_run == 0 && m_hold < H) begin
          m_hold++;
          if (m_hold == H) exp_o[0] = 1'b1;
        end
        m_run = 0;
      end
      exp_o[3] = m_acc;
      m_s2 = m_s1;
      m_s1 = ~button_in;
    end
    #1;
  endtask

  task automatic apply_reset();
    button_in = 1'b1;
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    button_in = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (dut_o !== 4'b0000) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got=%b want=0000", i, dut_o);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      total++;
      if (dut_o !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=0000", i, dut_o);
      end
    end
  endtask

  task automatic test_clean_press();
    apply_reset();
    button_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      total++;
      if (dut_o !== exp_o) begin
        bad++;
        $display("FAIL clean_press_model cyc=%0d got=%b want=%b", i, dut_o, exp_o);
      end
      total++;
      if ({pressed, press_pulse} !== {(i >= 6), (i == 6)}) begin
        bad++;
        $display("FAIL clean_press_timing edge=%0d got=%b%b want=%b%b",
                 i, pressed, press_pulse, (i >= 6), (i == 6));
      end
    end
  endtask

  task automatic test_bounce_press();
    int n_press = 0;
    int at = -1;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      button_in = (i < 4) ? (i % 2 == 1) : 1'b0;
      cycle();
      if (press_pulse) begin n_press++; at = i; end
      total++;
      if (dut_o !== exp_o) begin
        bad++;
        $display("FAIL bounce_press_model cyc=%0d got=%b want=%b", i, dut_o, exp_o);
      end
    end
    total++;
    if (n_press != 1 || at != 10) begin
      bad++;
      $display("FAIL bounce_press_count got=%0d@%0d want=1@10", n_press, at);
    end
  endtask

  task automatic test_hold();
    int n_hold = 0;
    int at = -1;
    apply_reset();
    button_in = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (hold_pulse) begin n_hold++; at = i; end
      total++;
      if (dut_o !== exp_o) begin
        bad++;
        $display("FAIL hold_model cyc=%0d got=%b want=%b", i, dut_o, exp_o);
      end
    end
    total++;
    if (n_hold != 1 || at != 16) begin
      bad++;
      $display("FAIL hold_count got=%0d@%0d want=1@16", n_hold, at);
    end
  endtask

  // Continues from test_hold with the button still held down
  task automatic test_release_bounce();
    int n_rel = 0;
    for (int i = 0; i < 14; i++) begin
      button_in = (i == 1) ? 1'b0 : 1'b1;
      cycle();
      if (release_pulse) n_rel++;
      total++;
      if (dut_o !== exp_o) begin
        bad++;
        $display("FAIL release_model cyc=%0d got=%b want=%b", i, dut_o, exp_o);
      end
      total++;
      if ({pressed, release_pulse} !== {(i < 8), (i == 8)}) begin
        bad++;
        $display("FAIL release_timing edge=%0d got=%b%b want=%b%b",
                 i, pressed, release_pulse, (i < 8), (i == 8));
      end
    end
    total++;
    if (n_rel != 1) begin
      bad++;
      $display("FAIL release_count got=%0d want=1", n_rel);
    end
  endtask

  task automatic test_reset_mid_press();
    apply_reset();
    button_in = 1'b0;
    repeat (9) cycle();
    total++;
    if (pressed !== 1'b1) begin
      bad++;
      $display("FAIL mid_press_setup got=%b want=1", pressed);
    end
    reset = 1'b1;
    cycle();
    total++;
    if (dut_o !== 4'b0000) begin
      bad++;
      $display("FAIL mid_press_reset got=%b want=0000", dut_o);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      total++;
      if (dut_o !== exp_o) begin
        bad++;
        $display("FAIL mid_press_model cyc=%0d got=%b want=%b", i, dut_o, exp_o);
      end
      total++;
      if ({press_pulse, release_pulse} !== {(i == 6), 1'b0}) begin
        bad++;
        $display("FAIL mid_press_repress edge=%0d got=%b%b want=%b0",
                 i, press_pulse, release_pulse, (i == 6));
      end
    end
  endtask

  task automatic test_random();
    int seg = 0;
    logic [2:0] prev = 3'b000;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        button_in = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 9);
      end
      seg--;
      reset = ($urandom_range(0, 299) == 0);
      cycle();
      total++;
      if (dut_o !== exp_o) begin
        bad++;
        $display("FAIL random_model cyc=%0d got=%b want=%b", i, dut_o, exp_o);
      end
      total++;
      if ($countones(dut_o[2:0]) > 1 || (prev != 3'b000 && dut_o[2:0] != 3'b000)) begin
        bad++;
        $display("FAIL random_exclusive cyc=%0d got=%b prev=%b want=isolated", i, dut_o[2:0], prev);
      end
      prev = dut_o[2:0];
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_hold();
    test_release_bounce();
    test_reset_mid_press();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
